// File: rtl/dff_init_seq_pkg.sv
// Shared types and width helpers for the dff_init_seq register-bank sequencer.
package dff_init_seq_pkg;

  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Bits needed to count 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dff_init_seq_wdog.sv
// Idle-cycle counter for the RUN state: raises o_fire on the WDOG_CYCLES-th
// consecutive idle RUN cycle. Only built when DFF_INIT_SEQ_WDOG_EN is defined.
module dff_init_seq_wdog
  import dff_init_seq_pkg::*;
#(
  parameter int WDOG_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  input  logic i_idle,
  output logic o_fire
);

  localparam int ICNT_W = cnt_w(WDOG_CYCLES);
  localparam logic [ICNT_W-1:0] ICNT_LAST = ICNT_W'(WDOG_CYCLES - 1);

  logic [ICNT_W-1:0] r_icnt;

  assign o_fire = i_run & i_idle & (r_icnt == ICNT_LAST);

  // Firing sends the bank to HOLD, so the count restarts along with it.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_run || !i_idle || o_fire) begin
      r_icnt <= '0;
    end else begin
      r_icnt <= r_icnt + 1'b1;
    end
  end

endmodule

// File: rtl/dff_init_seq.sv
// Init/hold/run sequencer for a WIDTH-bit flop bank with masked software re-init.
// Optional idle watchdog is enabled by defining DFF_INIT_SEQ_WDOG_EN.
module dff_init_seq
  import dff_init_seq_pkg::*;
#(
  parameter int               WIDTH       = 13,
  parameter logic [WIDTH-1:0] INIT_VAL    = 13'h0905,
  parameter logic [WIDTH-1:0] INIT_MASK   = 13'h1DFF,
  parameter int               HOLD_CYCLES = 4,
  parameter int               WDOG_CYCLES = 16
) (
  input  logic             C,
  input  logic             R,
  input  logic [WIDTH-1:0] D,
  input  logic             en,
  input  logic             reinit_req,
  input  logic [WIDTH-1:0] reinit_mask,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             done,
  output logic             ack,
  output logic             wdog_fire,
  output state_t           dbg_state
);

  localparam int               HCNT_W    = cnt_w(HOLD_CYCLES);
  localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(HOLD_CYCLES - 1);
  localparam logic [WIDTH-1:0]  IV        = INIT_VAL & INIT_MASK;

  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("HOLD_CYCLES must be at least 1");
  end
  if (WDOG_CYCLES < 1) begin : g_bad_wdog
    $error("WDOG_CYCLES must be at least 1");
  end

  state_t            r_state, w_state_nxt;
  logic [HCNT_W-1:0] r_hcnt, w_hcnt_nxt;
  logic [WIDTH-1:0]  r_q, w_q_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_ack, w_ack_nxt;
  logic              r_fire, w_fire_nxt;
  logic              w_wdog_fire;

`ifdef DFF_INIT_SEQ_WDOG_EN
  dff_init_seq_wdog #(
    .WDOG_CYCLES(WDOG_CYCLES)
  ) u_wdog (
    .i_clk (C),
    .i_rst (R),
    .i_run (r_state == ST_RUN),
    .i_idle(~en & ~reinit_req),
    .o_fire(w_wdog_fire)
  );
`else
  assign w_wdog_fire = 1'b0;
`endif

  // Re-init handshake: reinit_req is a level sampled only in RUN; acceptance
  // is signalled by a one-cycle ack, after which the requester drops the
  // request. A request still high on the first RUN cycle is accepted again.
  always_comb begin
    w_state_nxt = r_state;
    w_hcnt_nxt  = r_hcnt;
    w_q_nxt     = r_q;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_ack_nxt   = 1'b0;
    w_fire_nxt  = 1'b0;
    case (r_state)
      ST_HOLD: begin
        if (r_hcnt == HCNT_LAST) begin
          w_state_nxt = ST_RUN;
          w_hcnt_nxt  = '0;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else begin
          w_hcnt_nxt = r_hcnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (reinit_req) begin
          w_q_nxt     = (r_q & ~reinit_mask) | (IV & reinit_mask);
          w_ack_nxt   = 1'b1;
          w_state_nxt = ST_HOLD;
          w_hcnt_nxt  = '0;
          w_busy_nxt  = 1'b1;
        end else if (w_wdog_fire) begin
          w_q_nxt     = IV;
          w_fire_nxt  = 1'b1;
          w_state_nxt = ST_HOLD;
          w_hcnt_nxt  = '0;
          w_busy_nxt  = 1'b1;
        end else if (en) begin
          w_q_nxt = D;
        end
      end
      default: begin
        w_state_nxt = ST_HOLD;
        w_hcnt_nxt  = '0;
        w_busy_nxt  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge C) begin
    if (R) begin
      r_state <= ST_HOLD;
      r_hcnt  <= '0;
      r_q     <= IV;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
      r_ack   <= 1'b0;
      r_fire  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hcnt  <= w_hcnt_nxt;
      r_q     <= w_q_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_ack   <= w_ack_nxt;
      r_fire  <= w_fire_nxt;
    end
  end

  assign Q         = r_q;
  assign busy      = r_busy;
  assign done      = r_done;
  assign ack       = r_ack;
  assign wdog_fire = r_fire;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_dff_init_seq.sv
// Directed bench for dff_init_seq: timestamp-based reference model checked every
// cycle, plus hand-computed literal checks for each scenario.
module tb_dff_init_seq;
  import dff_init_seq_pkg::*;

  localparam int          W    = 13;
  localparam logic [12:0] IV   = 13'h0905 & 13'h1DFF;
  localparam int          HOLD = 4;
  localparam int          WDOG = 16;

  logic         C = 1'b0;
  logic         R, en, reinit_req;
  logic [W-1:0] D, reinit_mask, Q;
  logic         busy, done, ack, wdog_fire;
  state_t       dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  dff_init_seq dut (
    .C          (C),
    .R          (R),
    .D          (D),
    .en         (en),
    .reinit_req (reinit_req),
    .reinit_mask(reinit_mask),
    .Q          (Q),
    .busy       (busy),
    .done       (done),
    .ack        (ack),
    .wdog_fire  (wdog_fire),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 C = ~C;

  // ---------------- checker ----------------
  task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // RUN resumes at the edge numbered hold_until; before it the bank is frozen.
  int           cyc = 0;
  int           hold_until = 0;
  bit           m_valid = 1'b0;
  logic [W-1:0] m_q;
  bit           m_busy, m_done, m_ack, m_fire;
  int           m_idle = 0;

  always @(posedge C) begin
    cyc++;
    m_done = 1'b0;
    m_ack  = 1'b0;
    m_fire = 1'b0;
    if (R) begin
      m_valid    = 1'b1;
      m_q        = IV;
      m_busy     = 1'b1;
      hold_until = cyc + HOLD;
      m_idle     = 0;
    end else if (m_valid) begin
      if (cyc == hold_until) begin
        m_done = 1'b1;
        m_busy = 1'b0;
      end else if (cyc > hold_until) begin
        if (reinit_req) begin
          m_q        = (m_q & ~reinit_mask) | (IV & reinit_mask);
          m_ack      = 1'b1;
          m_busy     = 1'b1;
          hold_until = cyc + HOLD;
          m_idle     = 0;
        end else if (en) begin
          m_q    = D;
          m_idle = 0;
        end else begin
          m_idle++;
`ifdef DFF_INIT_SEQ_WDOG_EN
          if (m_idle == WDOG) begin
            m_q        = IV;
            m_fire     = 1'b1;
            m_busy     = 1'b1;
            hold_until = cyc + HOLD;
            m_idle     = 0;
          end
`endif
        end
      end
    end
    #1;
    if (m_valid) begin
      cmp("model_q",    Q,         m_q);
      cmp("model_busy", W'(busy),  W'(m_busy));
      cmp("model_done", W'(done),  W'(m_done));
      cmp("model_ack",  W'(ack),   W'(m_ack));
      cmp("model_wdog", W'(wdog_fire), W'(m_fire));
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge C);
    #2;
  endtask

  logic [W-1:0] load_tbl [4];

  initial begin
    load_tbl[0] = 13'h1555;
    load_tbl[1] = 13'h0AAA;
    load_tbl[2] = 13'h0001;
    load_tbl[3] = 13'h1000;

    R = 1'b1; en = 1'b0; reinit_req = 1'b0; D = '0; reinit_mask = '0;

    // 1. reset release
    repeat (3) step();
    cmp("rst_q", Q, 13'h0905);
    cmp("rst_busy", W'(busy), W'(1));
    cmp("rst_state", W'(dbg_state), W'(ST_HOLD));
    R = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      cmp("hold_busy", W'(busy), W'(1));
      cmp("hold_done", W'(done), W'(0));
      cmp("hold_q", Q, 13'h0905);
    end
    step();
    cmp("rst_done", W'(done), W'(1));
    cmp("rst_busy_low", W'(busy), W'(0));
    cmp("run_state", W'(dbg_state), W'(ST_RUN));
    step();
    cmp("done_pulse", W'(done), W'(0));

    // 2. load / hold
    en = 1'b1; D = 13'h1FFF;
    step();
    cmp("load_q", Q, 13'h1FFF);
    en = 1'b0; D = 13'h0000;
    step();
    cmp("noload_q", Q, 13'h1FFF);
    for (int k = 0; k < 4; k++) begin
      en = 1'b1; D = load_tbl[k];
      step();
      cmp("tbl_q", Q, load_tbl[k]);
    end
    en = 1'b1; D = 13'h1FFF;
    step();
    en = 1'b0;

    // 3. partial re-init
    reinit_req = 1'b1; reinit_mask = 13'h00FF;
    step();
    reinit_req = 1'b0; reinit_mask = '0;
    cmp("part_q", Q, 13'h1F05);
    cmp("part_ack", W'(ack), W'(1));
    cmp("part_busy", W'(busy), W'(1));
    for (int k = 1; k <= 3; k++) begin
      en = 1'b1; D = 13'h0123;
      step();
      cmp("part_frozen", Q, 13'h1F05);
      cmp("part_ack_off", W'(ack), W'(0));
    end
    en = 1'b0;
    step();
    cmp("part_done", W'(done), W'(1));

    // 4. collision: re-init beats load
    en = 1'b1; D = 13'h0FFF;
    step();
    cmp("coll_pre", Q, 13'h0FFF);
    reinit_req = 1'b1; D = 13'h0000; reinit_mask = 13'h1000;
    step();
    reinit_req = 1'b0; en = 1'b0; reinit_mask = '0;
    cmp("coll_q", Q, 13'h0FFF);
    cmp("coll_ack", W'(ack), W'(1));

    // 5. reset during the third HOLD cycle
    step();
    step();
    R = 1'b1;
    step();
    R = 1'b0;
    cmp("mid_rst_q", Q, 13'h0905);
    cmp("mid_rst_busy", W'(busy), W'(1));
    for (int k = 1; k <= 3; k++) begin
      step();
      cmp("mid_rst_wait", W'(done), W'(0));
    end
    step();
    cmp("mid_rst_done", W'(done), W'(1));

    // empty mask, then a request held across the whole HOLD window
    en = 1'b1; D = 13'h0AAA;
    step();
    en = 1'b0;
    reinit_req = 1'b1; reinit_mask = '0;
    step();
    cmp("mask0_q", Q, 13'h0AAA);
    cmp("mask0_ack", W'(ack), W'(1));
    reinit_mask = 13'h1FFF;
    repeat (3) step();
    cmp("held_no_ack", W'(ack), W'(0));
    step();
    cmp("held_done", W'(done), W'(1));
    step();
    cmp("held_reack", W'(ack), W'(1));
    cmp("held_q", Q, 13'h0905);
    reinit_req = 1'b0; reinit_mask = '0;
    repeat (4) step();
    cmp("held_done2", W'(done), W'(1));

    // 6. idle watchdog
    en = 1'b1; D = 13'h1234;
    step();
    en = 1'b0;
`ifdef DFF_INIT_SEQ_WDOG_EN
    repeat (15) step();
    cmp("wdog_early", W'(wdog_fire), W'(0));
    step();
    cmp("wdog_fire", W'(wdog_fire), W'(1));
    cmp("wdog_q", Q, 13'h0905);
    cmp("wdog_busy", W'(busy), W'(1));
    repeat (4) step();
    cmp("wdog_done", W'(done), W'(1));
`else
    repeat (17) step();
    cmp("nowdog_q", Q, 13'h1234);
    cmp("nowdog_fire", W'(wdog_fire), W'(0));
    cmp("nowdog_state", W'(dbg_state), W'(ST_RUN));
`endif

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dff_init_seq.md
# dff_init_seq

Sequencer for a WIDTH-bit register bank with per-bit initial values. It applies the defined init pattern on reset, holds it for a programmable settle window, and then runs the bank as an enabled D-register. It also services software re-init requests, which can cover the full bank or a masked subset of bits. It sits between the techmapped flop bank and the control logic that owns reset and re-init policy.

## Interface
Parameters:
- WIDTH, 13, bank width in bits
- INIT_VAL, 13'h0905, per-bit init value
- INIT_MASK, 13'h1DFF, 1 = bit has a defined init; 0 = undefined init, loaded as 0
- HOLD_CYCLES, 4, cycles the init pattern is held before RUN (≥1)
- WDOG_CYCLES, 16, consecutive idle RUN cycles before the watchdog fires (used only when the macro is defined)

Ports:
- C  in  1  clock, rising edge
- R  in  1  reset; synchronous, active-high
- D  in  WIDTH  next-state data for the bank
- en  in  1  load enable in RUN
- reinit_req  in  1  re-init request, level-sampled
- reinit_mask  in  WIDTH  bits to re-initialise, sampled together with reinit_req
- Q  out  WIDTH  bank contents, registered
- busy  out  1  high in HOLD
- done  out  1  one-cycle pulse on entry to RUN
- ack  out  1  one-cycle pulse when reinit_req is accepted
- wdog_fire  out  1  one-cycle watchdog pulse; constant 0 without the macro

## Operation
- Define IV = INIT_VAL & INIT_MASK.
- Two states: HOLD and RUN. Counter hcnt tracks HOLD progress; counter icnt tracks watchdog idle cycles.
- R=1 at an edge: state=HOLD, hcnt=0, Q=IV, busy=1, done=0, ack=0, wdog_fire=0, icnt=0. R dominates all other inputs.
- HOLD:
  - Q is frozen and hcnt increments each cycle.
  - When hcnt==HOLD_CYCLES-1, go to RUN: done=1 and busy=0 in the next cycle.
  - D, en and reinit_req are ignored.
- RUN:
  - en=1 → Q<=D. en=0 → Q holds.
  - reinit_req=1:
    - Q <= (Q & ~reinit_mask) | (IV & reinit_mask).
    - ack=1 for one cycle; state=HOLD, hcnt=0, busy=1.
  - reinit_req and en asserted together: re-init wins and D is discarded. Bits outside reinit_mask keep their current Q value, not D.
  - reinit_mask=0 still performs the HOLD sequence and pulses ack; Q is unchanged.
- A reinit_req that is held high across the HOLD window is re-accepted on the first RUN cycle. Requesters deassert after ack.
- done, ack and wdog_fire never exceed one cycle.

## Timing
- Reset: last edge with R=1 is e0. RUN begins after edge e0+HOLD_CYCLES; done is high for the cycle following that edge.
- Re-init: reinit_req sampled at edge t. After edge t: ack=1, busy=1, Q = masked init. After edge t+HOLD_CYCLES: RUN, done=1.
- Data latency is 1 cycle: D at edge t appears on Q after edge t.
- All outputs are registered. There are no combinational input-to-output paths.

## Configuration
- Macro DFF_INIT_SEQ_WDOG_EN.
- Defined:
  - In RUN, icnt counts consecutive cycles with en=0 && reinit_req=0. It resets on any en or reinit_req, and on leaving RUN.
  - When icnt reaches WDOG_CYCLES-1, the watchdog performs a full re-init (mask all ones, Q<=IV), pulses wdog_fire instead of ack, and enters HOLD.
  - reinit_req in the same cycle takes priority: ack pulses and wdog_fire does not.
- Undefined: no watchdog logic is instantiated; wdog_fire is tied 0 and WDOG_CYCLES is unused.

## Structure
- Package dff_init_seq_pkg holds:
  - state enum {ST_HOLD, ST_RUN}
  - clog2-based width helpers for hcnt and icnt
- Sub-module dff_init_seq_wdog (idle counter and fire pulse) is instantiated only under DFF_INIT_SEQ_WDOG_EN.

## Test plan
All scenarios use the default parameters.
1. Reset release: R=1 for 3 cycles, then 0 → Q=0x0905 throughout; busy=1 for 4 cycles after the last R edge; done pulses once; busy=0.
2. Load: in RUN, en=1 with D=0x1FFF → Q=0x1FFF next cycle. en=0 with D=0x0000 → Q stays 0x1FFF.
3. Partial re-init: Q=0x1FFF, reinit_req=1 with reinit_mask=0x00FF → next cycle Q=0x1F05, ack=1, busy=1. Q is frozen for 4 cycles, then done pulses.
4. Collision: reinit_req=1, en=1, D=0x0000, reinit_mask=0x1000 from Q=0x0FFF → Q=0x0FFF, ack=1. D is discarded.
5. Mid-HOLD reset: assert R during the third HOLD cycle after a re-init → Q=0x0905, hcnt restarts, and done arrives 4 cycles after R drops.
6. Watchdog (macro defined): in RUN with Q=0x1234, hold en=0 and reinit_req=0 for 16 cycles → wdog_fire pulses, Q=0x0905, HOLD. Repeat without the macro → no fire and Q=0x1234 holds.
